seg7_scan_driver: RTL and testbench

Parametrised, time-multiplexed seven-segment display driver for the board's common-anode digit banks. It holds an NDIG-digit hexadecimal value and decodes one digit at a time to active-low segment outputs, with matching active-low digit selects. It adds tear-free frame-aligned updates, per-digit decimal points and optional leading-zero blanking. It sits between any register-producing datapath and the display pins, replacing per-digit combinational decoders plus the separate 3-to-8 active-low select decoder.

---
 rtl/seg7_scan_driver.sv | 155 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver for common-anode digit banks.
// Holds an NDIG-digit hex value, scans one digit per DIV cycles, commits writes on frame boundaries.
module seg7_scan_driver #(
   parameter int NDIG = 8,
   parameter int DIV  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [4*NDIG-1:0] wr_data,
   input  logic [NDIG-1:0]   dp_in,
   input  logic              blank_lz,
   output logic [6:0]        seg,
   output logic              dp,
   output logic [NDIG-1:0]   an,
   output logic              busy
);

   localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int IW = $clog2(NDIG);
   localparam logic [PW-1:0]   PCNT_LAST = PW'(DIV - 1);
   localparam logic [PW-1:0]   PCNT_ONE  = PW'(1);
   localparam logic [IW-1:0]   IDX_LAST  = IW'(NDIG - 1);
   localparam logic [IW-1:0]   IDX_ONE   = IW'(1);
   localparam logic [NDIG-1:0] AN_ONE    = NDIG'(1);

   logic [PW-1:0]     pcnt_r;
   logic [IW-1:0]     idx_r;
   logic [4*NDIG-1:0] disp_r;
   logic [NDIG-1:0]   disp_dp_r;
   logic [4*NDIG-1:0] pend_r;
   logic [NDIG-1:0]   pend_dp_r;
   logic              pvalid_r;
   logic [6:0]        seg_r;
   logic              dp_r;
   logic [NDIG-1:0]   an_r;

   logic              tick_s;
   logic              frame_s;
   logic              zero_above_s;
   logic [NDIG-1:0]   blank_s;
   logic [3:0]        nib_s;
   logic [6:0]        seg_nxt_s;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] pat;
      case (nib)
         4'h0:    pat = 7'h01;
         4'h1:    pat = 7'h4F;
         4'h2:    pat = 7'h12;
         4'h3:    pat = 7'h06;
         4'h4:    pat = 7'h4C;
         4'h5:    pat = 7'h24;
         4'h6:    pat = 7'h20;
         4'h7:    pat = 7'h0F;
         4'h8:    pat = 7'h00;
         4'h9:    pat = 7'h04;
         4'hA:    pat = 7'h08;
         4'hB:    pat = 7'h60;
         4'hC:    pat = 7'h31;
         4'hD:    pat = 7'h42;
         4'hE:    pat = 7'h30;
         4'hF:    pat = 7'h38;
         default: pat = 7'h7F;
      endcase
      return pat;
   endfunction

   // Prescaler tick and frame boundary detection
   always_comb begin
      tick_s  = (pcnt_r == PCNT_LAST);
      frame_s = tick_s && (idx_r == IDX_LAST);
   end

   // Prescaler and digit index counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pcnt_r <= {PW{1'b0}};
         idx_r  <= {IW{1'b0}};
      end else if (tick_s) begin
         pcnt_r <= {PW{1'b0}};
         if (idx_r == IDX_LAST) begin
            idx_r <= {IW{1'b0}};
         end else begin
            idx_r <= idx_r + IDX_ONE;
         end
      end else begin
         pcnt_r <= pcnt_r + PCNT_ONE;
      end
   end

   // Pending/displayed value registers; a boundary write bypasses the pending stage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         disp_r    <= {(4*NDIG){1'b0}};
         disp_dp_r <= {NDIG{1'b0}};
         pend_r    <= {(4*NDIG){1'b0}};
         pend_dp_r <= {NDIG{1'b0}};
         pvalid_r  <= 1'b0;
      end else if (frame_s) begin
         if (wr_en) begin
            disp_r    <= wr_data;
            disp_dp_r <= dp_in;
         end else if (pvalid_r) begin
            disp_r    <= pend_r;
            disp_dp_r <= pend_dp_r;
         end else begin
            disp_r    <= disp_r;
            disp_dp_r <= disp_dp_r;
         end
         pvalid_r <= 1'b0;
      end else if (wr_en) begin
         pend_r    <= wr_data;
         pend_dp_r <= dp_in;
         pvalid_r  <= 1'b1;
      end else begin
         pvalid_r  <= pvalid_r;
      end
   end

   // Leading-zero mask: a digit blanks when it and every digit above it are zero
   always_comb begin
      zero_above_s = 1'b1;
      blank_s      = {NDIG{1'b0}};
      for (int i = NDIG - 1; i >= 0; i--) begin
         zero_above_s = zero_above_s & (disp_r[4*i +: 4] == 4'd0);
         blank_s[i]   = (i > 0) ? zero_above_s : 1'b0;
      end
      nib_s = disp_r[{idx_r, 2'b00} +: 4];
      if (blank_lz && blank_s[idx_r]) begin
         seg_nxt_s = 7'h7F;
      end else begin
         seg_nxt_s = hex_to_seg(nib_s);
      end
   end

   // Registered display outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg_r <= 7'h7F;
         dp_r  <= 1'b1;
         an_r  <= {NDIG{1'b1}};
      end else begin
         seg_r <= seg_nxt_s;
         dp_r  <= ~disp_dp_r[idx_r];
         an_r  <= ~(AN_ONE << idx_r);
      end
   end

   assign seg  = seg_r;
   assign dp   = dp_r;
   assign an   = an_r;
   assign busy = pvalid_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: frame-level model plus directed literal checks.
module tb_seg7_scan_driver;

   localparam int ND = 4;
   localparam int DV = 4;
   localparam int F  = ND * DV;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [15:0] wr_data = 16'h0000;
   logic [3:0]  dp_in = 4'h0;
   logic        blank_lz = 1'b0;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        busy;

   logic        wr_en2 = 1'b0;
   logic [31:0] wr_data2 = 32'h0;
   logic [7:0]  dp_in2 = 8'h0;
   logic [6:0]  seg2;
   logic        dp2;
   logic [7:0]  an2;
   logic        busy2;

   int tests = 0;
   int fails = 0;

   logic [6:0] dec_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

   seg7_scan_driver #(.NDIG(ND), .DIV(DV)) dut (
      .clk(clk), .reset(rst), .wr_en(wr_en), .wr_data(wr_data), .dp_in(dp_in),
      .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an), .busy(busy));

   seg7_scan_driver #(.NDIG(8), .DIV(2)) dut8 (
      .clk(clk), .reset(rst), .wr_en(wr_en2), .wr_data(wr_data2), .dp_in(dp_in2),
      .blank_lz(1'b0), .seg(seg2), .dp(dp2), .an(an2), .busy(busy2));

   always #5 clk = ~clk;

   // Frame-level model: position in frame from edge count, value state per the write rules
   int          n = 0;
   logic [15:0] disp_m = 16'h0, pend_m = 16'h0;
   logic [3:0]  ddp_m = 4'h0, pdp_m = 4'h0;
   logic        pv_m = 1'b0;
   logic [3:0]  e_an = 4'hF;
   logic [6:0]  e_seg = 7'h7F;
   logic        e_dp = 1'b1;
   logic        e_busy = 1'b0;

   always @(posedge clk or posedge rst) begin
      int pos, d;
      logic [15:0] upper;
      logic [3:0] one;
      if (rst) begin
         n = 0; disp_m = 16'h0; pend_m = 16'h0; ddp_m = 4'h0; pdp_m = 4'h0; pv_m = 1'b0;
         e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
         pos = n % F;
         d = pos / DV;
         one = 4'd1;
         e_an = ~(one << d);
         upper = disp_m >> (4 * d);
         if (blank_lz && d > 0 && upper == 16'h0) e_seg = 7'h7F;
         else e_seg = dec_tab[upper[3:0]];
         e_dp = ~ddp_m[d];
         if (pos == F - 1) begin
            if (wr_en) begin disp_m = wr_data; ddp_m = dp_in; end
            else if (pv_m) begin disp_m = pend_m; ddp_m = pdp_m; end
            pv_m = 1'b0;
         end else if (wr_en) begin
            pend_m = wr_data; pdp_m = dp_in; pv_m = 1'b1;
         end
         n++;
      end
      e_busy = pv_m;
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      tests++;
      if ({an, seg, dp, busy} !== {e_an, e_seg, e_dp, e_busy}) begin
         fails++;
         $display("FAIL model t=%0t: an/seg/dp/busy got %h/%h/%b/%b expected %h/%h/%b/%b",
                  $time, an, seg, dp, busy, e_an, e_seg, e_dp, e_busy);
      end
   end

   // 8-digit, DIV=2 instance: single-low select stepping every 2 cycles
   int cnt2 = 0;
   always @(negedge clk) begin
      logic [7:0] one8, exp8;
      if (rst) begin
         cnt2 = 0;
      end else begin
         cnt2++;
         if (cnt2 <= 48) begin
            one8 = 8'd1;
            exp8 = ~(one8 << (((cnt2 - 1) % 16) / 2));
            tests++;
            if (an2 !== exp8) begin
               fails++;
               $display("FAIL an8 cyc=%0d: got %h expected %h", cnt2, an2, exp8);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic wait_pos(input int p);
      int guard = 0;
      while ((n % F) != p && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) begin
         tests++; fails++;
         $display("FAIL wait_pos: position %0d not reached", p);
      end
   endtask

   task automatic wr(input logic [15:0] v, input logic [3:0] d);
      wr_en = 1'b1; wr_data = v; dp_in = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   initial begin
      cyc(3);
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_dp", 32'(dp), 32'h1);
      chk("rst_busy", 32'(busy), 32'h0);
      #1 rst = 1'b0;

      // idle scan after reset
      cyc(1);
      chk("idle_an0", 32'(an), 32'hE);
      chk("idle_seg0", 32'(seg), 32'h01);
      cyc(4); chk("idle_an1", 32'(an), 32'hD);
      cyc(4); chk("idle_an2", 32'(an), 32'hB);
      cyc(4); chk("idle_an3", 32'(an), 32'h7);
      cyc(20);

      // mid-frame write held pending until the boundary
      wait_pos(5);
      wr(16'h3A7F, 4'b0010);
      chk("pend_busy1", 32'(busy), 32'h1);
      wait_pos(15);
      chk("pend_busy2", 32'(busy), 32'h1);
      cyc(1);
      chk("commit_busy", 32'(busy), 32'h0);
      chk("old_last_an", 32'(an), 32'h7);
      cyc(1);
      chk("new_d0_an", 32'(an), 32'hE);
      chk("new_d0_seg", 32'(seg), 32'h38);
      chk("new_d0_dp", 32'(dp), 32'h1);
      cyc(4);
      chk("new_d1_seg", 32'(seg), 32'h0F);
      chk("new_d1_dp", 32'(dp), 32'h0);
      cyc(4); chk("new_d2_seg", 32'(seg), 32'h08);
      cyc(4); chk("new_d3_seg", 32'(seg), 32'h06);

      // two writes in one frame: last wins
      wait_pos(2);
      wr(16'h1111, 4'h0);
      wait_pos(8);
      wr(16'h2222, 4'h0);
      wait_pos(0);
      cyc(1); chk("lastwin_d0", 32'(seg), 32'h12);
      cyc(4); chk("lastwin_d1", 32'(seg), 32'h12);

      // write exactly on the boundary cycle
      wait_pos(15);
      wr(16'h0123, 4'h0);
      chk("bnd_busy", 32'(busy), 32'h0);
      cyc(1); chk("bnd_d0", 32'(seg), 32'h06);
      cyc(4); chk("bnd_d1", 32'(seg), 32'h12);

      // leading-zero blanking
      blank_lz = 1'b1;
      wait_pos(15);
      wr(16'h0050, 4'h0);
      cyc(1); chk("lz50_d0", 32'(seg), 32'h01);
      cyc(4); chk("lz50_d1", 32'(seg), 32'h24);
      cyc(4); chk("lz50_d2", 32'(seg), 32'h7F);
      cyc(4); chk("lz50_d3", 32'(seg), 32'h7F);
      wait_pos(15);
      wr(16'h0000, 4'b1000);
      cyc(1); chk("lz0_d0", 32'(seg), 32'h01);
      cyc(4); chk("lz0_d1", 32'(seg), 32'h7F);
      cyc(4); chk("lz0_d2", 32'(seg), 32'h7F);
      cyc(4);
      chk("lz0_d3_seg", 32'(seg), 32'h7F);
      chk("lz0_d3_dp", 32'(dp), 32'h0);
      blank_lz = 1'b0;

      // decode sweep
      for (int v = 0; v < 16; v++) begin
         wait_pos(15);
         wr({4{4'(v)}}, 4'h0);
         cyc(1);
         chk($sformatf("dec_%0h", v), 32'(seg), 32'(dec_tab[v]));
      end

      // reset mid-scan with a write pending
      wait_pos(3);
      wr(16'hBEEF, 4'hF);
      cyc(2);
      #2 rst = 1'b1;
      #1;
      chk("mrst_an", 32'(an), 32'hF);
      chk("mrst_seg", 32'(seg), 32'h7F);
      chk("mrst_dp", 32'(dp), 32'h1);
      chk("mrst_busy", 32'(busy), 32'h0);
      @(negedge clk);
      cyc(2);
      #1 rst = 1'b0;
      cyc(1);
      chk("post_an", 32'(an), 32'hE);
      chk("post_seg", 32'(seg), 32'h01);
      chk("post_busy", 32'(busy), 32'h0);
      cyc(40);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
